// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: FSM state encodings and result-type codes shared by the system controller blocks
package sys_ctrl_pkg;
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_SEND      = 2'd1;
   localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;
   localparam logic RES_RF  = 1'b0;
   localparam logic RES_ALU = 1'b1;
endpackage

// File: rtl/sys_ctrl_tx_slot.sv
// sys_ctrl_tx_slot: one-entry pending-result holding register (type + data + valid)
module sys_ctrl_tx_slot import sys_ctrl_pkg::*; #(
   parameter int DW = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          push,
   input  logic          push_type,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          vld,
   output logic          typ,
   output logic [DW-1:0] data
);
   // a push wins over a same-cycle pop so the slot can be refilled as it drains
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         vld  <= 1'b0;
         typ  <= RES_RF;
         data <= '0;
      end else if (push) begin
         vld  <= 1'b1;
         typ  <= push_type;
         data <= push_data;
      end else if (pop)
         vld <= 1'b0;
endmodule

// File: rtl/sys_ctrl_tx.sv
// sys_ctrl_tx: serialises RF (1 byte) and ALU (2 bytes, low first) results to a UART transmitter
module sys_ctrl_tx import sys_ctrl_pkg::*; #(
   parameter int ACK_TIMEOUT = 255,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RdData,
   input  logic                    RdData_Valid,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VALID,
   input  logic                    TX_BUSY,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   output logic                    CTRL_BUSY,
   output logic                    OVF,
   output logic                    ACK_ERR
);
   localparam int RW = 2*DATA_WIDTH;
   localparam int CW = $clog2(ACK_TIMEOUT+1);
   logic [1:0]            state;
   logic                  idx;
   logic [CW-1:0]         tmo_cnt;
   logic                  cur_have, cur_type;
   logic [RW-1:0]         cur_data;
   logic [DATA_WIDTH-1:0] tx_hold, cur_byte;
   logic                  slot_vld, slot_type;
   logic [RW-1:0]         slot_data;
   logic                  push, push_type, pop;
   logic [RW-1:0]         push_data, rf_data, first_data;
   logic                  first_vld, first_type, both, cur_free, to_cur, drop, is_last, abort, done;

   sys_ctrl_tx_slot #(.DW(RW)) u_slot (
      .CLK(CLK), .RST(RST), .push(push), .push_type(push_type), .push_data(push_data),
      .pop(pop), .vld(slot_vld), .typ(slot_type), .data(slot_data)
   );

   // route incoming strobes: ALU before RF; current register first, then slot, else drop
   always_comb begin
      rf_data    = {{DATA_WIDTH{1'b0}}, RdData};
      first_vld  = ALU_OUT_VALID | RdData_Valid;
      first_type = ALU_OUT_VALID ? RES_ALU : RES_RF;
      first_data = ALU_OUT_VALID ? ALU_OUT : rf_data;
      both       = ALU_OUT_VALID & RdData_Valid;
      cur_free   = state == ST_IDLE && !cur_have;
      pop        = cur_free && slot_vld;
      to_cur     = cur_free && !slot_vld;
      push       = to_cur ? both : first_vld && (!slot_vld || pop);
      push_type  = to_cur ? RES_RF : first_type;
      push_data  = to_cur ? rf_data : first_data;
      drop       = !to_cur && ((first_vld && slot_vld && !pop) || both);
      cur_byte   = idx ? cur_data[RW-1:DATA_WIDTH] : cur_data[DATA_WIDTH-1:0];
      is_last    = cur_type == RES_RF || idx;
      abort      = state == ST_WAIT_ACK && !TX_BUSY && tmo_cnt == CW'(ACK_TIMEOUT-1);
      done       = abort || (state == ST_WAIT_DONE && !TX_BUSY && is_last);
   end

   assign TX_D_VLD  = state == ST_SEND && !TX_BUSY;
   assign TX_P_DATA = TX_D_VLD ? cur_byte : tx_hold;
   assign CTRL_BUSY = state != ST_IDLE || cur_have || slot_vld;

   // capture the result being served, remember the last byte sent, flag dropped strobes
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         cur_have <= 1'b0;
         cur_type <= RES_RF;
         cur_data <= '0;
         tx_hold  <= '0;
         OVF      <= 1'b0;
      end else begin
         OVF <= drop;
         if (TX_D_VLD) tx_hold <= cur_byte;
         if (to_cur && first_vld) begin
            cur_have <= 1'b1;
            cur_type <= first_type;
            cur_data <= first_data;
         end else if (pop) begin
            cur_have <= 1'b1;
            cur_type <= slot_type;
            cur_data <= slot_data;
         end else if (done)
            cur_have <= 1'b0;
      end

   // byte handshake FSM with acknowledge timeout
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state   <= ST_IDLE;
         idx     <= 1'b0;
         tmo_cnt <= '0;
         ACK_ERR <= 1'b0;
      end else begin
         ACK_ERR <= abort;
         case (state)
            ST_IDLE:
               if (cur_have || slot_vld) begin
                  state <= ST_SEND;
                  idx   <= 1'b0;
               end
            ST_SEND:
               if (!TX_BUSY) begin
                  state   <= ST_WAIT_ACK;
                  tmo_cnt <= '0;
               end
            ST_WAIT_ACK:
               if (TX_BUSY) state <= ST_WAIT_DONE;
               else if (abort) state <= ST_IDLE;
               else tmo_cnt <= tmo_cnt + CW'(1);
            ST_WAIT_DONE:
               if (!TX_BUSY) begin
                  state <= is_last ? ST_IDLE : ST_SEND;
                  idx   <= 1'b1;
               end
            default: state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_sys_ctrl_tx.sv
// tb_sys_ctrl_tx: directed scoreboard bench for sys_ctrl_tx with a 10-cycle UART busy model
module tb_sys_ctrl_tx;
   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  RdData;
   logic        RdData_Valid;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_VALID;
   logic        TX_BUSY;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD, CTRL_BUSY, OVF, ACK_ERR;

   int checks = 0, errors = 0, cyc = 0;
   int ovf_cnt = 0, ack_cnt = 0, ack_cyc = 0, busy_left = 0;
   bit model_on = 1'b1;
   logic [7:0] exp_q[$];
   int vld_cycs[$];

   sys_ctrl_tx dut (
      .CLK(CLK), .RST(RST), .RdData(RdData), .RdData_Valid(RdData_Valid),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID), .TX_BUSY(TX_BUSY),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CTRL_BUSY(CTRL_BUSY),
      .OVF(OVF), .ACK_ERR(ACK_ERR)
   );

   initial forever #5 CLK = ~CLK;
   initial forever @(posedge CLK) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // UART model: busy for 10 cycles after each accepted byte
   initial begin
      bit v;
      TX_BUSY = 1'b0;
      forever begin
         @(negedge CLK);
         v = TX_D_VLD;
         @(posedge CLK);
         #1;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) TX_BUSY = 1'b0;
         end
         if (v && model_on) begin
            TX_BUSY = 1'b1;
            busy_left = 10;
         end
      end
   end

   // monitor: pop expected bytes on every TX_D_VLD, count OVF / ACK_ERR pulses
   initial begin
      bit prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (OVF) ovf_cnt++;
         if (ACK_ERR) begin
            ack_cnt++;
            ack_cyc = cyc;
         end
         if (TX_D_VLD) begin
            vld_cycs.push_back(cyc);
            chk("vld_back_to_back", {31'b0, prev}, 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %0h expected no byte", TX_P_DATA);
            end else
               chk("tx_byte", {24'b0, TX_P_DATA}, {24'b0, exp_q.pop_front()});
         end
         prev = TX_D_VLD;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic strobe(input bit av, input logic [15:0] a, input bit rv, input logic [7:0] r, output int s);
      @(posedge CLK);
      #1;
      ALU_OUT_VALID = av;
      ALU_OUT = a;
      RdData_Valid = rv;
      RdData = r;
      s = cyc;
      @(posedge CLK);
      #1;
      ALU_OUT_VALID = 1'b0;
      RdData_Valid = 1'b0;
      ALU_OUT = 16'($urandom);
      RdData = 8'($urandom);
   endtask

   task automatic wait_idle(input string name, output int c);
      int n = 0;
      do begin
         @(negedge CLK);
         #1;
         n++;
      end while ((CTRL_BUSY || TX_BUSY || exp_q.size() != 0) && n < 2000);
      c = cyc;
      chk({name, "_idle_timeout"}, n < 2000, 1);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_tx_p_data"}, {24'b0, TX_P_DATA}, 0);
      chk({name, "_tx_d_vld"}, {31'b0, TX_D_VLD}, 0);
      chk({name, "_ctrl_busy"}, {31'b0, CTRL_BUSY}, 0);
      chk({name, "_ovf"}, {31'b0, OVF}, 0);
      chk({name, "_ack_err"}, {31'b0, ACK_ERR}, 0);
   endtask

   initial begin
      int s, c, n0, o0, a0, n;
      RST = 1'b1;
      RdData = '0;
      RdData_Valid = 1'b0;
      ALU_OUT = '0;
      ALU_OUT_VALID = 1'b0;
      repeat (3) @(negedge CLK);
      chk_reset_outputs("in_reset");
      @(posedge CLK);
      #1;
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk_reset_outputs("after_reset");

      // single RF byte
      n0 = vld_cycs.size();
      exp_q.push_back(8'h5A);
      strobe(0, 16'h0, 1, 8'h5A, s);
      wait_idle("rf", c);
      chk("rf_vld_count", vld_cycs.size() - n0, 1);
      chk("rf_latency", vld_cycs[n0] - s, 2);
      chk("rf_busy_release", c - vld_cycs[n0], 12);
      chk("rf_hold", {24'b0, TX_P_DATA}, 8'h5A);

      // ALU two-byte result
      n0 = vld_cycs.size();
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'hBE);
      strobe(1, 16'hBEEF, 0, 8'h0, s);
      wait_idle("alu", c);
      chk("alu_vld_count", vld_cycs.size() - n0, 2);
      chk("alu_latency", vld_cycs[n0] - s, 2);
      chk("alu_byte_gap", vld_cycs[n0+1] - vld_cycs[n0], 12);

      // simultaneous strobes: ALU first, RF from the pending slot
      n0 = vld_cycs.size();
      o0 = ovf_cnt;
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h11);
      strobe(1, 16'h2233, 1, 8'h11, s);
      wait_idle("dual", c);
      chk("dual_vld_count", vld_cycs.size() - n0, 3);
      chk("dual_latency", vld_cycs[n0] - s, 2);
      chk("dual_slot_gap", vld_cycs[n0+2] - vld_cycs[n0+1], 13);
      chk("dual_ovf", ovf_cnt - o0, 0);

      // three strobes during one transfer: second queued, third dropped
      n0 = vld_cycs.size();
      o0 = ovf_cnt;
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h77);
      strobe(1, 16'h1234, 0, 8'h0, s);
      strobe(0, 16'h0, 1, 8'h77, s);
      strobe(1, 16'h9999, 0, 8'h0, s);
      wait_idle("ovf", c);
      chk("ovf_vld_count", vld_cycs.size() - n0, 3);
      chk("ovf_pulses", ovf_cnt - o0, 1);

      // double strobe into a full slot pulses OVF once
      n0 = vld_cycs.size();
      o0 = ovf_cnt;
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h01);
      strobe(1, 16'hAAAA, 0, 8'h0, s);
      strobe(0, 16'h0, 1, 8'h01, s);
      strobe(1, 16'h5555, 1, 8'h02, s);
      wait_idle("ovf2", c);
      chk("ovf2_vld_count", vld_cycs.size() - n0, 3);
      chk("ovf2_pulses", ovf_cnt - o0, 1);

      // TX_BUSY stuck low: acknowledge timeout aborts the high byte
      model_on = 1'b0;
      n0 = vld_cycs.size();
      a0 = ack_cnt;
      exp_q.push_back(8'h66);
      strobe(1, 16'h5566, 0, 8'h0, s);
      n = 0;
      do begin
         @(negedge CLK);
         #1;
         n++;
      end while (ack_cnt == a0 && n < 600);
      chk("ack_seen", n < 600, 1);
      chk("ack_delay", ack_cyc - vld_cycs[n0], 256);
      chk("ack_idle", {31'b0, CTRL_BUSY}, 0);
      repeat (30) @(negedge CLK);
      #1;
      chk("ack_pulses", ack_cnt - a0, 1);
      chk("ack_vld_count", vld_cycs.size() - n0, 1);
      model_on = 1'b1;

      // reset between low and high byte
      n0 = vld_cycs.size();
      exp_q.push_back(8'hFE);
      strobe(1, 16'hCAFE, 0, 8'h0, s);
      n = 0;
      do begin
         @(negedge CLK);
         #1;
         n++;
      end while (vld_cycs.size() == n0 && n < 50);
      chk("cafe_low_seen", n < 50, 1);
      repeat (4) @(posedge CLK);
      #3;
      RST = 1'b1;
      #1;
      chk_reset_outputs("mid_reset");
      @(posedge CLK);
      #2;
      RST = 1'b0;
      repeat (40) @(negedge CLK);
      #1;
      chk("cafe_vld_count", vld_cycs.size() - n0, 1);
      chk_reset_outputs("post_reset");
      n0 = vld_cycs.size();
      exp_q.push_back(8'h99);
      strobe(0, 16'h0, 1, 8'h99, s);
      wait_idle("recover", c);
      chk("recover_vld_count", vld_cycs.size() - n0, 1);
      chk("recover_latency", vld_cycs[n0] - s, 2);

      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
